skolem_sweep_checker: RTL and testbench

Exhaustive, clocked verifier that sits directly downstream of a combinational Skolem-function candidate. It sweeps every assignment of the NX universally quantified inputs and drives each one into the candidate. It samples the candidate's NY outputs together with the specification-relation verdict, and counts failing assignments. It streams each counterexample out through a one-deep valid/ready buffer, and reports pass/fail when the sweep completes.

---
 rtl/skolem_chk_pkg.sv | 21 ++
 rtl/skolem_chk_cex_buf.sv | 42 ++++
 rtl/skolem_sweep_checker.sv | 113 +++++++++++
 tb/tb_skolem_sweep_checker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/skolem_chk_pkg.sv
// Shared types and width helpers for the exhaustive Skolem-candidate sweep checker.
package skolem_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_EVAL   = 2'd2,
    ST_FIN    = 2'd3
  } state_e;

  // Settle counter only has to reach SETTLE-1.
  function automatic int cnt_w(input int settle);
    return (settle < 2) ? 1 : $clog2(settle);
  endfunction

  // One extra bit so a sweep where every assignment fails (2^NX) never wraps.
  function automatic int fcnt_w(input int nx);
    return nx + 1;
  endfunction

endpackage

// File: rtl/skolem_chk_cex_buf.sv
// One-deep valid/ready holding register for counterexamples {x, y}.
module skolem_chk_cex_buf #(
  parameter int NX = 3,
  parameter int NY = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [NX-1:0] i_x,
  input  logic [NY-1:0] i_y,
  input  logic          i_ready,
  output logic          o_free,
  output logic          o_valid,
  output logic [NX-1:0] o_x,
  output logic [NY-1:0] o_y
);

  logic          r_valid;
  logic [NX-1:0] r_x;
  logic [NY-1:0] r_y;

  // Free also when the held entry is leaving this very cycle.
  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_x     <= i_x;
      r_y     <= i_y;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/skolem_sweep_checker.sv
// Sweeps all 2^NX inputs through a combinational candidate, counts spec failures
// and streams each counterexample out through a one-deep valid/ready buffer.
module skolem_sweep_checker
  import skolem_chk_pkg::*;
#(
  parameter int NX     = 3,
  parameter int NY     = 3,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [NX-1:0] x_out,
  input  logic [NY-1:0] y_in,
  input  logic          spec_ok,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [NX:0]   fail_cnt,
  output logic          cex_valid,
  input  logic          cex_ready,
  output logic [NX-1:0] cex_x,
  output logic [NY-1:0] cex_y
);

  localparam int CW = cnt_w(SETTLE);
  localparam int FW = fcnt_w(NX);

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [NX-1:0] r_x;
  logic [FW-1:0] r_fail;
  logic          r_busy;
  logic          r_done;
  logic          r_pass;

  logic w_free;
  logic w_eval;
  logic w_load;
  logic w_adv;

  assign w_eval = (r_state == ST_EVAL);
  assign w_load = w_eval && !spec_ok && w_free;
  // A failing vector may only advance once its counterexample has been parked.
  assign w_adv  = w_eval && (spec_ok || w_free);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_fail  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_x     <= '0;
          r_fail  <= '0;
          r_pass  <= 1'b0;
          r_cnt   <= '0;
          r_busy  <= 1'b1;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == CW'(SETTLE - 1)) r_state <= ST_EVAL;
          else                          r_cnt   <= r_cnt + 1'b1;
        end
        ST_EVAL: begin
          if (w_load) r_fail <= r_fail + 1'b1;
          if (w_adv) begin
            if (&r_x) begin
              r_state <= ST_FIN;
            end else begin
              r_x     <= r_x + 1'b1;
              r_cnt   <= '0;
              r_state <= ST_SETTLE;
            end
          end
        end
        ST_FIN: begin
          r_done  <= 1'b1;
          r_pass  <= (r_fail == '0);
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  skolem_chk_cex_buf #(.NX(NX), .NY(NY)) u_cex_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_x     (r_x),
    .i_y     (y_in),
    .i_ready (cex_ready),
    .o_free  (w_free),
    .o_valid (cex_valid),
    .o_x     (cex_x),
    .o_y     (cex_y)
  );

  assign x_out    = r_x;
  assign busy     = r_busy;
  assign done     = r_done;
  assign pass     = r_pass;
  assign fail_cnt = r_fail;

endmodule

// File: tb/tb_skolem_sweep_checker.sv
// Scoreboard bench: expected counterexamples are queued when a sweep is launched
// and popped as the DUT hands them over.
module tb_skolem_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  // SETTLE=1 instance, candidate y = x ^ 3
  logic       start1 = 1'b0, ready1 = 1'b1, ok1;
  logic [2:0] x1, y1, cx1, cy1;
  logic       busy1, done1, pass1, cv1;
  logic [3:0] fc1;

  // SETTLE=3 instance, y driven cycle by cycle from the bench
  logic       start3 = 1'b0, ready3 = 1'b1, ok3 = 1'b0;
  logic [2:0] x3, y3 = 3'd0, cx3, cy3;
  logic       busy3, done3, pass3, cv3;
  logic [3:0] fc3;

  int n_cmp = 0;
  int n_bad = 0;
  int mode  = 0;
  logic [5:0] sb1[$];
  logic [5:0] sb3[$];

  always #5 clk = ~clk;

  always_comb begin
    y1  = x1 ^ 3'b011;
    ok1 = (mode == 0) ? 1'b1 : (mode == 1) ? (x1 != 3'd5) : 1'b0;
  end

  skolem_sweep_checker #(.NX(3), .NY(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start1), .x_out(x1), .y_in(y1), .spec_ok(ok1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_cnt(fc1), .cex_valid(cv1),
    .cex_ready(ready1), .cex_x(cx1), .cex_y(cy1)
  );

  skolem_sweep_checker #(.NX(3), .NY(3), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .x_out(x3), .y_in(y3), .spec_ok(ok3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_cnt(fc3), .cex_valid(cv3),
    .cex_ready(ready3), .cex_x(cx3), .cex_y(cy3)
  );

  // m: 0 all pass, 1 fail only at x=5, 2 all fail. rel: cycle from which ready=1 (0 = always).
  task automatic run_sweep(input int m, input int rel, input bit hold, input bit chk_x,
                           output int dcyc);
    int cyc;
    logic [5:0] e;
    logic [2:0] xv;
    mode = m;
    for (int x = 0; x < 8; x++) begin
      xv = 3'(x);
      if (m == 2 || (m == 1 && x == 5)) sb1.push_back({xv, xv ^ 3'b011});
    end
    ready1 = (rel == 0);
    start1 = 1'b1;
    @(posedge clk); #1;
    if (!hold) start1 = 1'b0;
    cyc  = 0;
    dcyc = -1;
    while (cyc < 300 && (dcyc < 0 || cyc < dcyc + 3)) begin
      ready1 = (rel == 0) || (cyc + 1 >= rel);
      @(negedge clk);
      if (chk_x && cyc < 16) begin
        n_cmp++;
        if (x1 !== 3'(cyc / 2)) begin
          n_bad++;
          $display("FAIL x_step cycle %0d: got %0d want %0d", cyc + 1, x1, cyc / 2);
        end
      end
      if (cv1 && ready1) begin
        n_cmp++;
        if (sb1.size() == 0) begin
          n_bad++;
          $display("FAIL cex_unexpected: got x=%0d y=%0d want none", cx1, cy1);
        end else begin
          e = sb1.pop_front();
          if ({cx1, cy1} !== e) begin
            n_bad++;
            $display("FAIL cex_data: got x=%0d y=%0d want x=%0d y=%0d", cx1, cy1, e[5:3], e[2:0]);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (dcyc >= 0) begin
        n_cmp++;
        if (done1 !== 1'b0) begin n_bad++; $display("FAIL done_pulse: got %b want 0", done1); end
      end else if (done1) begin
        dcyc   = cyc;
        start1 = 1'b0;
      end
    end
    start1 = 1'b0;
    n_cmp++;
    if (dcyc < 0) begin n_bad++; $display("FAIL sweep_timeout: no done within 300 cycles"); end
    n_cmp++;
    if (sb1.size() != 0) begin
      n_bad++;
      $display("FAIL cex_missing: got %0d unreported want 0", sb1.size());
      sb1.delete();
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({x1, busy1, done1, pass1, fc1, cv1, cx1, cy1} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_dut1: got %h want 0", {x1, busy1, done1, pass1, fc1, cv1, cx1, cy1});
    end
    n_cmp++;
    if ({x3, busy3, done3, pass3, fc3, cv3, cx3, cy3} !== 17'd0) begin
      n_bad++;
      $display("FAIL reset_dut3: got %h want 0", {x3, busy3, done3, pass3, fc3, cv3, cx3, cy3});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    int d;
    run_sweep(0, 0, 1'b0, 1'b1, d);
    n_cmp++;
    if (d !== 17) begin n_bad++; $display("FAIL clean_done_cycle: got %0d want 17", d); end
    n_cmp++;
    if (fc1 !== 4'd0) begin n_bad++; $display("FAIL clean_fail_cnt: got %0d want 0", fc1); end
    n_cmp++;
    if (pass1 !== 1'b1) begin n_bad++; $display("FAIL clean_pass: got %b want 1", pass1); end
    n_cmp++;
    if (busy1 !== 1'b0) begin n_bad++; $display("FAIL clean_busy_after: got %b want 0", busy1); end
  endtask

  task automatic test_single_cex;
    int d;
    run_sweep(1, 0, 1'b0, 1'b1, d);
    n_cmp++;
    if (d !== 17) begin n_bad++; $display("FAIL single_done_cycle: got %0d want 17", d); end
    n_cmp++;
    if (fc1 !== 4'd1) begin n_bad++; $display("FAIL single_fail_cnt: got %0d want 1", fc1); end
    n_cmp++;
    if (pass1 !== 1'b0) begin n_bad++; $display("FAIL single_pass: got %b want 0", pass1); end
  endtask

  task automatic test_stall;
    int d;
    run_sweep(2, 20, 1'b0, 1'b0, d);
    n_cmp++;
    if (d !== 33) begin n_bad++; $display("FAIL stall_done_cycle: got %0d want 33", d); end
    n_cmp++;
    if (fc1 !== 4'b1000) begin n_bad++; $display("FAIL stall_fail_cnt: got %0d want 8", fc1); end
    n_cmp++;
    if (pass1 !== 1'b0) begin n_bad++; $display("FAIL stall_pass: got %b want 0", pass1); end
  endtask

  task automatic test_back_to_back;
    int d;
    run_sweep(1, 0, 1'b1, 1'b1, d);
    n_cmp++;
    if (d !== 17) begin n_bad++; $display("FAIL hold_done_cycle: got %0d want 17", d); end
    n_cmp++;
    if (fc1 !== 4'd1) begin n_bad++; $display("FAIL hold_fail_cnt: got %0d want 1", fc1); end
    run_sweep(1, 0, 1'b0, 1'b1, d);
    n_cmp++;
    if (d !== 17) begin n_bad++; $display("FAIL repeat_done_cycle: got %0d want 17", d); end
    n_cmp++;
    if (fc1 !== 4'd1) begin n_bad++; $display("FAIL repeat_fail_cnt: got %0d want 1", fc1); end
  endtask

  task automatic test_reset_mid;
    int d;
    mode   = 2;
    ready1 = 1'b0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    n_cmp++;
    if (cv1 !== 1'b1) begin n_bad++; $display("FAIL midreset_pre_valid: got %b want 1", cv1); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({x1, busy1, done1, pass1, fc1, cv1, cx1, cy1} !== 17'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %h want 0", {x1, busy1, done1, pass1, fc1, cv1, cx1, cy1});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({busy1, cv1, x1} !== 5'd0) begin
      n_bad++;
      $display("FAIL midreset_held: got %h want 0", {busy1, cv1, x1});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_sweep(0, 0, 1'b0, 1'b1, d);
    n_cmp++;
    if (d !== 17 || pass1 !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_resweep: got done=%0d pass=%b want 17/1", d, pass1);
    end
  endtask

  task automatic test_settle3;
    int cyc, dcyc;
    logic [5:0] e;
    logic [2:0] xv, g;
    for (int x = 0; x < 8; x++) begin
      xv = 3'(x);
      sb3.push_back({xv, xv ^ 3'b011});
    end
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc  = 0;
    dcyc = -1;
    while (cyc < 300 && (dcyc < 0 || cyc < dcyc + 3)) begin
      g  = 3'($urandom_range(1, 7));
      y3 = (((cyc + 1) % 4) == 0) ? (x3 ^ 3'b011) : (x3 ^ 3'b011 ^ g);
      @(negedge clk);
      if (cyc < 32) begin
        n_cmp++;
        if (x3 !== 3'(cyc / 4)) begin
          n_bad++;
          $display("FAIL settle3_x_step cycle %0d: got %0d want %0d", cyc + 1, x3, cyc / 4);
        end
      end
      if (cv3) begin
        n_cmp++;
        if (sb3.size() == 0) begin
          n_bad++;
          $display("FAIL settle3_cex_unexpected: got x=%0d y=%0d want none", cx3, cy3);
        end else begin
          e = sb3.pop_front();
          if ({cx3, cy3} !== e) begin
            n_bad++;
            $display("FAIL settle3_cex: got x=%0d y=%0d want x=%0d y=%0d", cx3, cy3, e[5:3], e[2:0]);
          end
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (dcyc < 0 && done3) dcyc = cyc;
    end
    n_cmp++;
    if (dcyc !== 33) begin n_bad++; $display("FAIL settle3_done_cycle: got %0d want 33", dcyc); end
    n_cmp++;
    if (fc3 !== 4'd8 || sb3.size() != 0) begin
      n_bad++;
      $display("FAIL settle3_count: got fail_cnt=%0d left=%0d want 8/0", fc3, sb3.size());
      sb3.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean();
    test_single_cex();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_settle3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
